rr_decode_arbiter: RTL and testbench
====================================

# rr_decode_arbiter

Round-robin arbiter that shares one downstream resource between four requesters. It produces a one-hot grant through a 2-to-4 index decoder. Grants are held while the owner keeps its request high, up to a programmable maximum. A one-cycle break-before-make gap separates consecutive grants. The block sits in front of any 4-way shared datapath that is selected by a one-hot enable.

## Interface
Parameters:
- HOLD_MAX, default 15: maximum consecutive grant cycles per owner; 0 disables the limit; legal range 0..255.
- CW, default 8: hold counter width; must satisfy 2**CW > HOLD_MAX.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  level request per requester, bit n = requester n.
- gnt  out  4  one-hot grant, registered; all zero when idle.
- gnt_id  out  2  binary index of current/last owner, registered.
- gnt_valid  out  1  high whenever gnt is non-zero.
- timeout  out  1  one-cycle pulse on a forced release by HOLD_MAX.

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the winner by searching from (last_owner+1) mod 4 upward with wrap.
  - Go to GRANT, load owner, clear hold_cnt.
  - If req == 0, stay in IDLE.
- GRANT, leaving for IDLE:
  - The state goes to IDLE if req[owner] == 0 at the sampling edge.
  - It also goes to IDLE if HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1; this case pulses timeout.
  - On either exit, last_owner <= owner.
- GRANT, staying: otherwise remain in GRANT and hold_cnt increments.
- gnt = decode(owner) in GRANT, 0000 in IDLE; exactly one bit or none is ever set.
- Requests from non-owners never pre-empt; they wait for the IDLE gap.
- A lone requester that is released or timed out is re-granted after the one IDLE cycle if it still requests.
- Request changes from non-owners during GRANT have no effect until the next IDLE arbitration.
- Reset:
  - Outputs: gnt = 0000, gnt_id = 00, gnt_valid = 0, timeout = 0.
  - Internal: state = IDLE, hold_cnt = 0, last_owner = 3, so the first search starts at requester 0.
  - Reset takes effect asynchronously, including mid-grant; gnt drops without waiting for a clock edge.

## Timing
- Grant latency: req seen in IDLE at edge k -> gnt asserted after edge k (1 cycle).
- Release latency: req[owner] low at edge k -> gnt = 0000 after edge k.
- Timeout:
  - gnt is high for exactly HOLD_MAX cycles.
  - timeout is high during the first IDLE cycle after the forced release, concurrent with gnt = 0000.
- Minimum gap between any two grants: 1 cycle with gnt = 0000.
- Throughput with continuous demand: HOLD_MAX grant cycles per HOLD_MAX+1 cycles.
- All outputs are registered; there is no combinational path from req to any output.

## Structure
Shared package arb_pkg:
- N_REQ = 4 and ID_W = 2.
- State enum {IDLE, GRANT}.
- A next_owner(last, req) round-robin search function.

Sub-module gnt_decode: the 2-to-4 one-hot decoder (index in, 4-bit one-hot out, enable forces 0000). It is instantiated once to drive gnt from the owner register.

## Test plan
- Reset mid-grant:
  - Stimulus: hold req = 0010 in GRANT, assert rst asynchronously between clock edges.
  - Response: gnt = 0000 and gnt_valid = 0 immediately.
  - After rst is released with req still 0010, the grant is 0010 after the first edge.
- Single requester:
  - Stimulus: req = 0100 for 3 cycles, then 0000.
  - Response: gnt = 0100 for 3 cycles starting one cycle after req, gnt_id = 10, then 0000.
  - timeout never pulses.
- Full contention:
  - Stimulus: HOLD_MAX = 4, req = 1111 constant.
  - Response: gnt sequence is 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, 0001.
  - timeout pulses in each 0000 cycle.
- Voluntary rotation:
  - Stimulus: req = 1001; owner 0 drops req after 2 cycles.
  - Response: gnt = 0001 x2, 0000, 1000.
  - If req[0] reasserts, it does not win before requester 3 releases.
- Lone re-grant:
  - Stimulus: HOLD_MAX = 3, req = 1000 held.
  - Response: gnt = 1000 x3, 0000 with timeout = 1, then 1000 x3 repeating.
- Unlimited hold:
  - Stimulus: HOLD_MAX = 0, req = 0011 held for 300 cycles.
  - Response: gnt = 0001 for all 300 cycles, with no timeout and no counter wrap effect.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin grant arbiter.
// Holds the requester count, the owner-index width, the FSM state type and the search function.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin search: the first requester found scanning upward from last+1
  // with wrap. Walking the offsets from largest to smallest lets the nearest
  // candidate overwrite the others. Offset N_REQ wraps to last itself, so a
  // lone requester can win again.
  function automatic logic [ID_W-1:0] next_owner(input logic [ID_W-1:0] last,
                                                  input logic [N_REQ-1:0] req);
    logic [ID_W-1:0] idx;
    next_owner = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + ID_W'(i);
      if (req[idx]) next_owner = idx;
    end
  endfunction

endpackage

// File: rtl/gnt_decode.sv
// 2-to-4 one-hot decoder for the grant vector.
// The output is 0000 while en is low, so an idle arbiter never drives a stale owner.
module gnt_decode
  import arb_pkg::*;
(
  input  logic            en,
  input  logic [ID_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for four requesters, with a hold limit and a one-cycle idle gap between grants.
// The grant is a decode of registered state only, so no path exists from req to any output.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit             HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CW-1:0]  HOLD_LAST = HOLD_EN ? CW'(HOLD_MAX - 1) : '0;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  owner, owner_nxt;
  logic [ID_W-1:0]  last_owner, last_owner_nxt;
  logic [CW-1:0]    hold_cnt, hold_cnt_nxt;
  logic             timeout_nxt;
  logic             own_req;
  logic             hit_limit;
  logic             leave_grant;
  logic             gnt_en;

  assign own_req     = req[owner];
  assign hit_limit   = HOLD_EN && (hold_cnt == HOLD_LAST);
  assign leave_grant = !own_req || hit_limit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)       state_nxt = GRANT;
      GRANT:   if (leave_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    gnt_en    = (state == GRANT);
    gnt_valid = gnt_en;
  end

  // Owner, rotation pointer, hold counter and the timeout pulse
  always_comb begin
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_cnt_nxt   = hold_cnt;
    timeout_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt    = next_owner(last_owner, req);
          hold_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (leave_grant) begin
          last_owner_nxt = owner;
          // The pulse marks only a forced release; an owner that drops on its own is not timed out.
          timeout_nxt    = hit_limit && own_req;
        end else begin
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      last_owner <= ID_W'(N_REQ - 1);
      hold_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_cnt_nxt;
      timeout    <= timeout_nxt;
    end
  end

  assign gnt_id = owner;

  gnt_decode u_gnt_decode (
    .en     (gnt_en),
    .idx    (owner),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: four instances with different hold limits share one request bus.
// Directed scenario tasks are followed by a random run that is checked against an integer reference model.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_o [4];
  logic [1:0] id_o  [4];
  logic       vld_o [4];
  logic       to_o  [4];

  int errors = 0;
  int checks = 0;

  // Hold limit of each instance: index 0..3 -> 15, 4, 3, 0
  int hmax [4] = '{15, 4, 3, 0};

  // Reference model state, one entry per instance
  int m_busy [4];
  int m_own  [4];
  int m_last [4];
  int m_held [4];
  int m_to   [4];

  always #5 clk = ~clk;

  rr_decode_arbiter #(.HOLD_MAX(15), .CW(8)) u_h15 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[0]), .gnt_id(id_o[0]),
    .gnt_valid(vld_o[0]), .timeout(to_o[0]));
  rr_decode_arbiter #(.HOLD_MAX(4), .CW(8)) u_h4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[1]), .gnt_id(id_o[1]),
    .gnt_valid(vld_o[1]), .timeout(to_o[1]));
  rr_decode_arbiter #(.HOLD_MAX(3), .CW(2)) u_h3 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[2]), .gnt_id(id_o[2]),
    .gnt_valid(vld_o[2]), .timeout(to_o[2]));
  rr_decode_arbiter #(.HOLD_MAX(0), .CW(4)) u_h0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[3]), .gnt_id(id_o[3]),
    .gnt_valid(vld_o[3]), .timeout(to_o[3]));

  // Apply a request value, let one rising edge sample it, then settle 1 ns past the edge.
  task automatic drive(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 4; u++) begin
      m_busy[u] = 0;
      m_own[u]  = 0;
      m_last[u] = 3;
      m_held[u] = 0;
      m_to[u]   = 0;
    end
  endtask

  // One clock of arbitration rules. The model counts cycles already granted,
  // and a release by the owner takes precedence over the hold limit.
  task automatic model_step(input logic [3:0] r);
    int c;
    bit found;
    for (int u = 0; u < 4; u++) begin
      m_to[u] = 0;
      if (m_busy[u] == 0) begin
        if (r != 4'b0000) begin
          found = 0;
          for (int k = 1; k <= 4; k++) begin
            c = (m_last[u] + k) % 4;
            if (!found && r[c]) begin
              m_own[u] = c;
              found = 1;
            end
          end
          m_busy[u] = 1;
          m_held[u] = 1;
        end
      end else if (!r[m_own[u]]) begin
        m_busy[u] = 0;
        m_last[u] = m_own[u];
      end else if (hmax[u] != 0 && m_held[u] == hmax[u]) begin
        m_busy[u] = 0;
        m_last[u] = m_own[u];
        m_to[u]   = 1;
      end else begin
        m_held[u] = m_held[u] + 1;
      end
    end
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (gnt_o[u] !== 4'b0000 || id_o[u] !== 2'b00 || vld_o[u] !== 1'b0 || to_o[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_u%0d: gnt=%b id=%b vld=%b to=%b, expected 0000/00/0/0",
                 u, gnt_o[u], id_o[u], vld_o[u], to_o[u]);
      end
    end
    // Clock edges while reset is held must not grant.
    req = 4'b1111;
    @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (gnt_o[u] !== 4'b0000 || vld_o[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_u%0d: gnt=%b vld=%b, expected 0000/0", u, gnt_o[u], vld_o[u]);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100);
      checks++;
      if (gnt_o[0] !== 4'b0100 || id_o[0] !== 2'b10 || vld_o[0] !== 1'b1 || to_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_c%0d: gnt=%b id=%b vld=%b to=%b, expected 0100/10/1/0",
                 i, gnt_o[0], id_o[0], vld_o[0], to_o[0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0000);
      checks++;
      if (gnt_o[0] !== 4'b0000 || id_o[0] !== 2'b10 || vld_o[0] !== 1'b0 || to_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_rel%0d: gnt=%b id=%b vld=%b to=%b, expected 0000/10/0/0",
                 i, gnt_o[0], id_o[0], vld_o[0], to_o[0]);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] eg;
    logic       et;
    do_reset();
    for (int s = 0; s < 21; s++) begin
      drive(4'b1111);
      if (s % 5 == 4) begin
        eg = 4'b0000;
        et = 1'b1;
      end else begin
        eg = 4'(1 << ((s / 5) % 4));
        et = 1'b0;
      end
      checks++;
      if (gnt_o[1] !== eg || to_o[1] !== et) begin
        errors++;
        $display("FAIL contention_s%0d: gnt=%b to=%b, expected %b/%b", s, gnt_o[1], to_o[1], eg, et);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] rs [8] = '{4'b1001, 4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 4'b0001};
    logic [3:0] es [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(rs[i]);
      checks++;
      if (gnt_o[0] !== es[i] || to_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL rotation_c%0d: gnt=%b to=%b, expected %b/0", i, gnt_o[0], to_o[0], es[i]);
      end
    end
  endtask

  task automatic test_lone();
    logic [3:0] eg;
    logic       et;
    do_reset();
    for (int s = 0; s < 12; s++) begin
      drive(4'b1000);
      eg = (s % 4 == 3) ? 4'b0000 : 4'b1000;
      et = (s % 4 == 3);
      checks++;
      if (gnt_o[2] !== eg || to_o[2] !== et || id_o[2] !== 2'b11) begin
        errors++;
        $display("FAIL lone_s%0d: gnt=%b to=%b id=%b, expected %b/%b/11",
                 s, gnt_o[2], to_o[2], id_o[2], eg, et);
      end
    end
  endtask

  task automatic test_unlimited();
    do_reset();
    for (int s = 0; s < 300; s++) begin
      drive(4'b0011);
      checks++;
      if (gnt_o[3] !== 4'b0001 || to_o[3] !== 1'b0 || vld_o[3] !== 1'b1) begin
        errors++;
        $display("FAIL unlimited_s%0d: gnt=%b to=%b vld=%b, expected 0001/0/1",
                 s, gnt_o[3], to_o[3], vld_o[3]);
      end
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    drive(4'b0010);
    drive(4'b0010);
    checks++;
    if (gnt_o[0] !== 4'b0010) begin
      errors++;
      $display("FAIL midgrant_pre: gnt=%b, expected 0010", gnt_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt_o[0] !== 4'b0000 || vld_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midgrant_async: gnt=%b vld=%b, expected 0000/0", gnt_o[0], vld_o[0]);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (gnt_o[0] !== 4'b0010 || id_o[0] !== 2'b01) begin
      errors++;
      $display("FAIL midgrant_regrant: gnt=%b id=%b, expected 0010/01", gnt_o[0], id_o[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] eg;
    do_reset();
    r = 4'b0000;
    for (int s = 0; s < 800; s++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
      drive(r);
      model_step(r);
      for (int u = 0; u < 4; u++) begin
        eg = (m_busy[u] != 0) ? 4'(1 << m_own[u]) : 4'b0000;
        checks++;
        if (gnt_o[u] !== eg || id_o[u] !== 2'(m_own[u]) ||
            vld_o[u] !== (m_busy[u] != 0) || to_o[u] !== (m_to[u] != 0)) begin
          errors++;
          $display("FAIL random_s%0d_u%0d: req=%b gnt=%b id=%b vld=%b to=%b, expected %b/%0d/%0d/%0d",
                   s, u, r, gnt_o[u], id_o[u], vld_o[u], to_o[u], eg, m_own[u], m_busy[u], m_to[u]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_lone();
    test_unlimited();
    test_reset_midgrant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
